// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit with accumulate ops, flush abort and done pulse.
module mdu_iter #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       MDUOp,
  input  logic             HIWrite,
  input  logic             LOWrite,
  input  logic             Flush,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  localparam int CW = $clog2(WIDTH + MUL_CYCLES + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0] op;
  logic [WIDTH-1:0] a, b, a_mag, b_mag, q_fix, r_fix;
  logic [WIDTH:0] rem, t, diff;
  logic [2*WIDTH-1:0] pa, pb, prod, acc_n;
  logic neg_q, neg_r, b_zero, sgn_in, is_div, start_ok, last, ge, done_n;
  assign sgn_in   = ~MDUOp[0];
  assign is_div   = MDUOp[2:1] == 2'b01;
  assign start_ok = state == IDLE && Start && !Flush;
  assign last     = cnt == '0;
  assign a_mag    = (sgn_in && A[WIDTH-1]) ? -A : A;
  assign b_mag    = (sgn_in && B[WIDTH-1]) ? -B : B;
  // Sign-extending both operands to 2*WIDTH makes one multiplier serve signed and unsigned ops.
  assign pa    = {{WIDTH{~op[0] & a[WIDTH-1]}}, a};
  assign pb    = {{WIDTH{~op[0] & b[WIDTH-1]}}, b};
  assign prod  = pa * pb;
  assign acc_n = op[2] ? (op[1] ? {HI, LO} - prod : {HI, LO} + prod) : prod;
  // Restoring step: a doubles as the dividend/quotient shift register.
  assign t     = {rem[WIDTH-1:0], a[WIDTH-1]};
  assign diff  = t - {1'b0, b};
  assign ge    = ~diff[WIDTH];
  assign q_fix = neg_q ? -a : a;
  assign r_fix = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
  always_comb begin
    state_n = (state != IDLE && Flush) ? IDLE
            : state == IDLE ? (start_ok ? (is_div ? DIV : MUL) : IDLE)
            : state == MUL  ? (last ? IDLE : MUL)
            : state == DIV  ? (last ? FIX : DIV)
            : IDLE;
    done_n  = !Flush && ((state == MUL && last) || state == FIX);
  end
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= IDLE;
      cnt   <= '0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
      HI    <= '0;
      LO    <= '0;
    end else begin
      state <= state_n;
      Busy  <= state_n != IDLE;
      Done  <= done_n;
      if (start_ok) begin
        op     <= MDUOp;
        a      <= is_div ? a_mag : A;
        b      <= is_div ? b_mag : B;
        rem    <= '0;
        cnt    <= is_div ? CW'(WIDTH - 1) : CW'(MUL_CYCLES - 1);
        neg_q  <= sgn_in && (A[WIDTH-1] ^ B[WIDTH-1]);
        neg_r  <= sgn_in && A[WIDTH-1];
        b_zero <= B == '0;
      end else if (state == IDLE && !Flush) begin
        if (HIWrite) HI <= A;
        if (LOWrite) LO <= A;
      end
      if (state == MUL || state == DIV) cnt <= cnt - 1'b1;
      if (state == DIV) begin
        rem <= ge ? diff : t;
        a   <= {a[WIDTH-2:0], ge};
      end
      if (!Flush && state == MUL && last) {HI, LO} <= acc_n;
      if (!Flush && state == FIX && !b_zero) begin
        HI <= r_fix;
        LO <= q_fix;
      end
    end
  end
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: randomized and directed checks of mdu_iter against an arithmetic HI/LO model.
module tb_mdu_iter;
  localparam int W = 32;
  localparam int MC = 5;
  logic clk = 0;
  logic Reset, Start, HIWrite, LOWrite, Flush;
  logic [2:0] MDUOp;
  logic [W-1:0] A, B, HI, LO;
  logic Busy, Done;
  logic [W-1:0] m_hi, m_lo;
  int checks = 0;
  int errors = 0;

  mdu_iter #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
    .Clk(clk), .Reset(Reset), .Start(Start), .MDUOp(MDUOp), .HIWrite(HIWrite),
    .LOWrite(LOWrite), .Flush(Flush), .A(A), .B(B), .Busy(Busy), .Done(Done),
    .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain 64-bit arithmetic on the architectural HI/LO pair.
  task automatic model(input logic [2:0] op, input logic [W-1:0] a, b, output int lat);
    longint sa, sb, q, r;
    logic [63:0] p, acc;
    if (op[2:1] == 2'b01) begin
      lat = W + 1;
      if (b != 0) begin
        sa = op[0] ? longint'({32'b0, a}) : longint'($signed(a));
        sb = op[0] ? longint'({32'b0, b}) : longint'($signed(b));
        q = sa / sb;
        r = sa % sb;
        m_lo = q[31:0];
        m_hi = r[31:0];
      end
    end else begin
      lat = MC;
      sa = op[0] ? longint'({32'b0, a}) : longint'($signed(a));
      sb = op[0] ? longint'({32'b0, b}) : longint'($signed(b));
      p = sa * sb;
      acc = {m_hi, m_lo};
      acc = op[2] ? (op[1] ? acc - p : acc + p) : p;
      {m_hi, m_lo} = acc;
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, b);
    int n, lat;
    logic [W-1:0] o_hi, o_lo;
    bit moved;
    o_hi = m_hi;
    o_lo = m_lo;
    model(op, a, b, lat);
    Start = 1; MDUOp = op; A = a; B = b;
    tick();
    Start = 0; A = $urandom; B = $urandom; MDUOp = 3'($urandom);
    checks++;
    if (Busy !== 1'b1 || Done !== 1'b0) begin
      errors++;
      $display("FAIL accept op=%0d busy=%b done=%b required busy=1 done=0", op, Busy, Done);
    end
    n = 0;
    moved = 0;
    while (Busy === 1'b1 && n < 200) begin
      if (HI !== o_hi || LO !== o_lo) moved = 1;
      n++;
      tick();
    end
    checks++;
    if (n != lat) begin
      errors++;
      $display("FAIL latency op=%0d got %0d required %0d", op, n, lat);
    end
    checks++;
    if (moved) begin
      errors++;
      $display("FAIL hilo_stable_while_busy op=%0d", op);
    end
    checks++;
    if (Done !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse op=%0d got %b required 1", op, Done);
    end
    checks++;
    if (HI !== m_hi || LO !== m_lo) begin
      errors++;
      $display("FAIL result op=%0d a=%h b=%h got HI=%h LO=%h required HI=%h LO=%h",
               op, a, b, HI, LO, m_hi, m_lo);
    end
  endtask

  task automatic write_hilo(input logic hw, lw, input logic [W-1:0] v);
    HIWrite = hw; LOWrite = lw; A = v;
    tick();
    HIWrite = 0; LOWrite = 0;
    if (hw) m_hi = v;
    if (lw) m_lo = v;
    checks++;
    if (HI !== m_hi || LO !== m_lo || Done !== 1'b0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL mthi_mtlo got HI=%h LO=%h done=%b busy=%b required HI=%h LO=%h done=0 busy=0",
               HI, LO, Done, Busy, m_hi, m_lo);
    end
  endtask

  task automatic idle_tick();
    tick();
    checks++;
    if (Done !== 1'b0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_done done=%b busy=%b required 0 0", Done, Busy);
    end
  endtask

  task automatic test_reset();
    Reset = 0; Start = 0; HIWrite = 0; LOWrite = 0; Flush = 0; MDUOp = 0; A = 0; B = 0;
    repeat (3) tick();
    Reset = 1;
    m_hi = 0; m_lo = 0;
    checks++;
    if (HI !== 0 || LO !== 0 || Busy !== 0 || Done !== 0) begin
      errors++;
      $display("FAIL reset got HI=%h LO=%h busy=%b done=%b required all 0", HI, LO, Busy, Done);
    end
  endtask

  task automatic test_mul();
    run_op(3'b000, 32'hFFFFFFFE, 32'd3);
    checks++;
    if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFA) begin
      errors++;
      $display("FAIL mult_directed got %h_%h required ffffffff_fffffffa", HI, LO);
    end
    idle_tick();
    run_op(3'b001, 32'hFFFFFFFE, 32'd3);
    checks++;
    if (HI !== 32'h2 || LO !== 32'hFFFFFFFA) begin
      errors++;
      $display("FAIL multu_directed got %h_%h required 00000002_fffffffa", HI, LO);
    end
    idle_tick();
  endtask

  task automatic test_div();
    run_op(3'b010, 32'hFFFFFFF9, 32'd2);
    checks++;
    if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFD) begin
      errors++;
      $display("FAIL div_neg got HI=%h LO=%h required ffffffff fffffffd", HI, LO);
    end
    run_op(3'b011, 32'd7, 32'd2);
    checks++;
    if (HI !== 32'd1 || LO !== 32'd3) begin
      errors++;
      $display("FAIL divu_7_2 got HI=%h LO=%h required 1 3", HI, LO);
    end
    run_op(3'b010, 32'h80000000, 32'hFFFFFFFF);
    checks++;
    if (HI !== 32'd0 || LO !== 32'h80000000) begin
      errors++;
      $display("FAIL div_overflow got HI=%h LO=%h required 0 80000000", HI, LO);
    end
    idle_tick();
  endtask

  task automatic test_div_zero();
    write_hilo(0, 1, 32'h22);
    write_hilo(1, 0, 32'h11);
    run_op(3'b010, 32'd5, 32'd0);
    checks++;
    if (HI !== 32'h11 || LO !== 32'h22) begin
      errors++;
      $display("FAIL div_by_zero got HI=%h LO=%h required 11 22", HI, LO);
    end
    idle_tick();
  endtask

  task automatic test_accumulate();
    write_hilo(1, 1, 32'h0);
    write_hilo(0, 1, 32'hFFFFFFFF);
    run_op(3'b101, 32'd1, 32'd1);
    checks++;
    if (HI !== 32'd1 || LO !== 32'd0) begin
      errors++;
      $display("FAIL maddu_carry got HI=%h LO=%h required 1 0", HI, LO);
    end
    idle_tick();
    write_hilo(1, 1, 32'h0);
    run_op(3'b110, 32'd1, 32'd1);
    checks++;
    if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL msub_borrow got HI=%h LO=%h required ffffffff ffffffff", HI, LO);
    end
  endtask

  task automatic test_back_to_back();
    run_op(3'b000, 32'd6, 32'd7);
    run_op(3'b100, 32'hFFFFFFFF, 32'd2);
    run_op(3'b011, 32'd100, 32'd9);
    run_op(3'b111, 32'h12345678, 32'h9ABCDEF0);
    idle_tick();
  endtask

  task automatic test_flush();
    Start = 1; MDUOp = 3'b010; A = 32'd1000; B = 32'd7;
    tick();
    Start = 0; HIWrite = 1; A = 32'h5;
    tick();
    HIWrite = 0;
    tick();
    Flush = 1;
    tick();
    Flush = 0;
    checks++;
    if (Busy !== 0 || Done !== 0 || HI !== m_hi || LO !== m_lo) begin
      errors++;
      $display("FAIL flush_div got busy=%b done=%b HI=%h LO=%h required 0 0 %h %h",
               Busy, Done, HI, LO, m_hi, m_lo);
    end
    idle_tick();
    Flush = 1; Start = 1; HIWrite = 1; LOWrite = 1; MDUOp = 3'b000; A = 32'h77; B = 32'h3;
    tick();
    Flush = 0; Start = 0; HIWrite = 0; LOWrite = 0;
    checks++;
    if (Busy !== 0 || HI !== m_hi || LO !== m_lo) begin
      errors++;
      $display("FAIL flush_idle got busy=%b HI=%h LO=%h required 0 %h %h", Busy, HI, LO, m_hi, m_lo);
    end
    idle_tick();
  endtask

  task automatic test_reset_mid();
    write_hilo(1, 1, 32'hABCD);
    Start = 1; MDUOp = 3'b000; A = 32'd9; B = 32'd9;
    tick();
    Start = 0;
    tick();
    Reset = 0;
    tick();
    Reset = 1;
    m_hi = 0; m_lo = 0;
    checks++;
    if (HI !== 0 || LO !== 0 || Busy !== 0 || Done !== 0) begin
      errors++;
      $display("FAIL reset_mid got HI=%h LO=%h busy=%b done=%b required all 0", HI, LO, Busy, Done);
    end
    idle_tick();
    run_op(3'b000, 32'd3, 32'd4);
    checks++;
    if (HI !== 0 || LO !== 32'd12) begin
      errors++;
      $display("FAIL mult_after_reset got HI=%h LO=%h required 0 c", HI, LO);
    end
    idle_tick();
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic [2:0] op;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(5))
        0: b = 0;
        1: b = 32'($urandom_range(15));
        2: a = 32'h80000000;
        3: b = 32'hFFFFFFFF;
        default: ;
      endcase
      if ($urandom_range(7) == 0) write_hilo(1'($urandom), 1'($urandom), $urandom);
      run_op(op, a, b);
      if ($urandom_range(1) == 0) idle_tick();
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_accumulate();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised multiply/divide unit for the execute stage; successor to the fixed-latency MDU.
- Adds parametrised operand width and multiply latency, a true iterative restoring divider, MADD/MSUB accumulate ops, a Flush abort for exceptions, and a Done pulse.
- The hazard unit stalls dependent instructions on Start|Busy.

Parameters:
- WIDTH, 32: operand and HI/LO width. Must be at least 4.
- MUL_CYCLES, 5: number of Busy cycles for multiply and accumulate ops. Must be at least 1.

Ports:
- Clk  input  1: clock; all state updates on its rising edge.
- Reset  input  1: synchronous, active-low reset.
- Start  input  1: request to begin the operation selected by MDUOp.
- MDUOp  input  3: operation select. 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU.
- HIWrite  input  1: mthi, writes A into HI.
- LOWrite  input  1: mtlo, writes A into LO.
- Flush  input  1: abort any in-flight operation (exception/eret).
- A  input  WIDTH: operand rs.
- B  input  WIDTH: operand rt.
- Busy  output  1: registered; high while an operation is in flight.
- Done  output  1: one-cycle pulse when a completed result becomes visible.
- HI  output  WIDTH: HI register.
- LO  output  WIDTH: LO register.

Behaviour:
- Reset: Clk is the single clock. Reset is synchronous and active-low: Reset==0 at a rising edge of Clk sets HI=0, LO=0, Busy=0, Done=0, counter=0, state=IDLE. This overrides every other input, including mid-operation.
- Edge priority: Reset > Flush > Start > HIWrite/LOWrite.
- States: IDLE, MUL, DIV, FIX.
- Start acceptance:
  - Accepted only in IDLE with Flush=0. A and B are latched and Busy=1 from the next cycle.
  - Start while Busy is ignored.
  - HIWrite/LOWrite are honoured only in IDLE with Start=0 and Flush=0; the write lands at that edge. Both may be set together.
- MUL (ops 000, 001, 1xx):
  - Busy is high for exactly MUL_CYCLES cycles.
  - At the final edge: MULT/MULTU set {HI,LO} = product (signed or unsigned, 2*WIDTH bits).
  - MADD(U) sets {HI,LO} = {HI,LO} + product; MSUB(U) sets {HI,LO} = {HI,LO} - product; both wrap modulo 2^(2*WIDTH).
  - Signedness comes from MDUOp[0]: 0 = signed, 1 = unsigned.
  - Busy falls at the same edge HI/LO update.
- DIV/FIX (ops 010, 011):
  - Signed ops take operand magnitudes.
  - Restoring shift-subtract produces 1 quotient bit per cycle for WIDTH cycles in DIV.
  - FIX then takes 1 cycle for sign correction and write-back, so Busy is high for WIDTH+1 cycles.
  - Result: LO = quotient, truncated toward zero; HI = remainder, with the sign of the dividend.
  - B==0: HI and LO are unchanged, latency is identical, and Done still pulses.
  - Signed -2^(WIDTH-1) / -1: LO = 0x80..0 (wrap), HI = 0.
- Done:
  - High for exactly the one cycle following a completing edge (first cycle with Busy=0 and new HI/LO).
  - Not asserted for HIWrite/LOWrite or aborted operations.
- Back-to-back: Start may be asserted in the first cycle after Busy falls; no bubble.
- Flush:
  - In MUL/DIV/FIX: next edge forces IDLE and Busy=0; HI/LO keep their pre-operation values; no Done.
  - Flush with Start in the same cycle: Start is discarded.
  - Flush in IDLE: suppresses HIWrite/LOWrite, otherwise no effect.
- HI/LO never change while Busy=1 except at the completing edge.
- Width: internal product and accumulator are 2*WIDTH bits; divider remainder register is WIDTH+1 bits.

Test Plan:
- MULT with A=0xFFFFFFFE, B=3 -> Busy for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA, and Done pulses once. Repeat as MULTU -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV with A=0xFFFFFFF9 (-7), B=2 -> Busy for 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 -> LO=3, HI=1. Signed 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- LOWrite A=0x22, then HIWrite A=0x11, then DIV with A=5, B=0 -> after 33 Busy cycles HI=0x11, LO=0x22, and Done pulses.
- Accumulate ops:
  - HI=0, LO=0xFFFFFFFF, then MADDU A=1, B=1 -> HI=1, LO=0.
  - From HI=LO=0, MSUB A=1, B=1 -> HI=LO=0xFFFFFFFF.
  - Start MULT in the cycle after Done -> accepted immediately.
- During DIV, assert Flush in the 3rd Busy cycle -> Busy=0 next cycle, HI/LO unchanged, no Done. Start with Flush in the same cycle -> ignored. HIWrite with A=0x5 while Busy -> HI unchanged.
- Drive Reset=0 for one edge in the 2nd cycle of a MULT -> HI=LO=0, Busy=0, Done=0 after that edge. After release, MULT 3*4 -> LO=12, HI=0.
